// File: rtl/shift_ui_pkg.sv
// shift_ui_pkg: state encoding and timing defaults shared by the shift-register front end and top
package shift_ui_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        REPEAT   = 3'd3,
        REL_DB   = 3'd4
    } state_t;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 16;
    localparam int DEF_REPEAT_PERIOD   = 8;
endpackage

// File: rtl/shift_step_conditioner_if.sv
// shift_step_conditioner_if: raw pushbutton/switch inputs and conditioned step/control outputs
interface shift_step_conditioner_if;
    logic       key_n;
    logic [7:0] sw;
    logic       step;
    logic [7:0] ctrl;
    logic       held;
    logic [7:0] step_count;
    modport master (output key_n, sw, input step, ctrl, held, step_count);
    modport slave  (input key_n, sw, output step, ctrl, held, step_count);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a parameterized reset value
module sync_2ff #(
    parameter int           W  = 1,
    parameter logic [W-1:0] RV = '0
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1;
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            s1 <= RV;
            q  <= RV;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/shift_step_conditioner.sv
// shift_step_conditioner: debounced, auto-repeating step strobe with a per-step switch snapshot
module shift_step_conditioner
    import shift_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = 8
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    shift_step_conditioner_if.slave  bus
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             key_s;
    logic             pressed_s;
    logic [7:0]       sw_s;
    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n, timer_inc;
    logic             fire;

    sync_2ff #(.W(1), .RV(1'b1)) u_key_sync (.CLK(CLK), .RSTN(RSTN), .d(bus.key_n), .q(key_s));
    sync_2ff #(.W(8), .RV(8'h00)) u_sw_sync (.CLK(CLK), .RSTN(RSTN), .d(bus.sw), .q(sw_s));

    assign pressed_s = ~key_s;
    // Saturate so a non-repeating hold cannot wrap back into a false match
    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;
    assign bus.held  = state inside {HELD, REPEAT, REL_DB};

    always_comb begin
        state_n = state;
        timer_n = timer_inc;
        fire    = 1'b0;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (pressed_s) state_n = PRESS_DB;
            end
            PRESS_DB:
                if (!pressed_s) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else if (timer == DB_LAST) begin
                    state_n = HELD;
                    timer_n = '0;
                    fire    = 1'b1;
                end
            HELD:
                if (!pressed_s) begin
                    state_n = REL_DB;
                    timer_n = '0;
                end else if (REPEAT_EN && timer == RD_LAST) begin
                    state_n = REPEAT;
                    timer_n = '0;
                    fire    = 1'b1;
                end
            REPEAT:
                if (!pressed_s) begin
                    state_n = REL_DB;
                    timer_n = '0;
                end else if (timer == RP_LAST) begin
                    timer_n = '0;
                    fire    = 1'b1;
                end
            REL_DB:
                if (pressed_s) begin
                    state_n = HELD;
                    timer_n = '0;
                end else if (timer == DB_LAST) begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state          <= IDLE;
            timer          <= '0;
            bus.step       <= 1'b0;
            bus.ctrl       <= '0;
            bus.step_count <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bus.step <= fire;
            if (fire) begin
                bus.ctrl       <= sw_s;
                bus.step_count <= bus.step_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_shift_step_conditioner.sv
// tb_shift_step_conditioner: scoreboard bench for step timing, control snapshot and counter behaviour
module tb_shift_step_conditioner;
    typedef struct {
        int         cyc;
        logic [7:0] ctrl;
        logic [7:0] cnt;
    } exp_t;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [7:0] last_sw = 8'd0;
    exp_t q[$];

    shift_step_conditioner_if bus ();

    shift_step_conditioner dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest expected step exactly
    always @(negedge CLK) begin
        if (bus.step === 1'b1) begin
            chk("unexpected_step", q.size() != 0, 1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("step_cycle", cyc, e.cyc);
                chk("step_ctrl", bus.ctrl, e.ctrl);
                chk("step_count", bus.step_count, e.cnt);
            end
        end else if (q.size() != 0 && cyc > q[0].cyc) begin
            chk("missing_step", bus.step, 1);
            void'(q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input logic [7:0] v);
        bus.sw    = v;
        bus.key_n = 1'b0;
        last_sw   = v;
        exp_cnt++;
        q.push_back('{cyc + 7, v, exp_cnt});
    endtask

    initial begin
        bus.key_n = 1'b0;
        bus.sw    = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_step", bus.step, 0);
            chk("rst_ctrl", bus.ctrl, 0);
            chk("rst_held", bus.held, 0);
            chk("rst_count", bus.step_count, 0);
        end
        bus.key_n = 1'b1;
        RSTN      = 1'b1;
        tick(10);
        chk("idle_held", bus.held, 0);
        chk("idle_count", bus.step_count, 0);

        press(8'hA5);
        tick(9);
        chk("press_held", bus.held, 1);
        chk("press_ctrl", bus.ctrl, 8'hA5);
        chk("press_count", bus.step_count, 1);
        bus.sw = 8'h3C;
        tick(4);
        chk("sw_change_ctrl", bus.ctrl, 8'hA5);
        bus.key_n = 1'b1;
        tick(8);
        chk("release_held", bus.held, 0);

        bus.key_n = 1'b0;
        tick(3);
        bus.key_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("glitch_held", bus.held, 0);
        end
        chk("glitch_count", bus.step_count, 1);

        press(8'h5A);
        for (int i = 0; i < 6; i++) begin
            exp_cnt++;
            q.push_back('{cyc + 7 + 16 + 8 * i, 8'h5A, exp_cnt});
        end
        tick(67);
        bus.key_n = 1'b1;
        tick(12);
        chk("repeat_count", bus.step_count, 8);
        chk("repeat_drained", q.size(), 0);

        press(8'hC3);
        tick(10);
        bus.key_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            chk("bounce_held_hi", bus.held, 1);
        end
        bus.key_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("bounce_held", bus.held, 1);
        end
        bus.key_n = 1'b1;
        tick(10);
        chk("bounce_count", bus.step_count, 9);
        chk("bounce_released", bus.held, 0);

        while (exp_cnt != 8'd0) begin
            press(8'($urandom_range(0, 255)));
            tick(8);
            bus.key_n = 1'b1;
            tick(9);
        end
        chk("wrap_count", bus.step_count, 0);
        chk("wrap_ctrl", bus.ctrl, last_sw);

        press(8'h96);
        exp_cnt++;
        q.push_back('{cyc + 23, 8'h96, exp_cnt});
        tick(28);
        chk("pre_rst_count", bus.step_count, 2);
        RSTN = 1'b0;
        tick(1);
        chk("mid_rst_step", bus.step, 0);
        chk("mid_rst_ctrl", bus.ctrl, 0);
        chk("mid_rst_held", bus.held, 0);
        chk("mid_rst_count", bus.step_count, 0);
        tick(4);
        bus.key_n = 1'b1;
        RSTN      = 1'b1;
        exp_cnt   = 8'd0;
        tick(10);
        chk("post_rst_count", bus.step_count, 0);
        chk("final_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
